// File: rtl/sram_bus_arbiter.sv
// Two-master sram-like bus arbiter: data master has fixed priority over instruction fetch,
// an in-order owner FIFO steers each memory response back to the master that issued it.
module sram_bus_arbiter #(
  parameter int MAX_OUTST = 4
) (
  input  logic        clk,
  input  logic        resetn,
  // instruction-fetch master
  input  logic        inst_req,
  input  logic        inst_wr,
  input  logic [1:0]  inst_size,
  input  logic [3:0]  inst_wstrb,
  input  logic [31:0] inst_addr,
  input  logic [31:0] inst_wdata,
  output logic        inst_addr_ok,
  output logic        inst_data_ok,
  output logic [31:0] inst_rdata,
  // data master
  input  logic        data_req,
  input  logic        data_wr,
  input  logic [1:0]  data_size,
  input  logic [3:0]  data_wstrb,
  input  logic [31:0] data_addr,
  input  logic [31:0] data_wdata,
  output logic        data_addr_ok,
  output logic        data_data_ok,
  output logic [31:0] data_rdata,
  // shared memory port
  output logic        mem_req,
  output logic        mem_wr,
  output logic [1:0]  mem_size,
  output logic [3:0]  mem_wstrb,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic        mem_addr_ok,
  input  logic        mem_data_ok,
  input  logic [31:0] mem_rdata
);

  localparam int PTR_W = (MAX_OUTST > 1) ? $clog2(MAX_OUTST) : 1;
  localparam int CNT_W = $clog2(MAX_OUTST + 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(MAX_OUTST);
  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(MAX_OUTST - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    HOLD_I = 2'd1,
    HOLD_D = 2'd2
  } state_e;

  state_e               state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [PTR_W-1:0]     rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0]     wr_ptr_q, wr_ptr_d;
  logic [MAX_OUTST-1:0] owner_q, owner_d;

  logic full_s;
  logic grant_s;
  logic sel_data_s;
  logic accept_s;
  logic pop_s;
  logic head_s;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    if (p == PTR_LAST) begin
      ptr_inc = '0;
    end else begin
      ptr_inc = p + PTR_W'(1);
    end
  endfunction

  assign full_s = (cnt_q == CNT_FULL);

  // Grant selection and request-stage next state; a stalled grant locks the owner
  always_comb begin
    grant_s    = 1'b0;
    sel_data_s = 1'b0;
    state_d    = state_q;
    case (state_q)
      IDLE: begin
        if (!full_s && data_req) begin
          grant_s    = 1'b1;
          sel_data_s = 1'b1;
          state_d    = mem_addr_ok ? IDLE : HOLD_D;
        end else if (!full_s && inst_req) begin
          grant_s    = 1'b1;
          sel_data_s = 1'b0;
          state_d    = mem_addr_ok ? IDLE : HOLD_I;
        end else begin
          grant_s = 1'b0;
          state_d = IDLE;
        end
      end
      // Slot was reserved on entry, so fullness is not rechecked while holding
      HOLD_I: begin
        grant_s    = inst_req;
        sel_data_s = 1'b0;
        if (inst_req && mem_addr_ok) begin
          state_d = IDLE;
        end else begin
          state_d = HOLD_I;
        end
      end
      HOLD_D: begin
        grant_s    = data_req;
        sel_data_s = 1'b1;
        if (data_req && mem_addr_ok) begin
          state_d = IDLE;
        end else begin
          state_d = HOLD_D;
        end
      end
      default: begin
        grant_s = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  // Request field mux onto the shared port
  always_comb begin
    mem_req = grant_s & resetn;
    if (sel_data_s) begin
      mem_wr    = data_wr;
      mem_size  = data_size;
      mem_wstrb = data_wstrb;
      mem_addr  = data_addr;
      mem_wdata = data_wdata;
    end else begin
      mem_wr    = inst_wr;
      mem_size  = inst_size;
      mem_wstrb = inst_wstrb;
      mem_addr  = inst_addr;
      mem_wdata = inst_wdata;
    end
  end

  assign accept_s     = mem_req & mem_addr_ok;
  assign inst_addr_ok = accept_s & ~sel_data_s;
  assign data_addr_ok = accept_s & sel_data_s;

  assign head_s = owner_q[rd_ptr_q];
  // Responses with nothing outstanding are dropped without touching the FIFO
  assign pop_s  = mem_data_ok & (cnt_q != '0);

  assign inst_data_ok = pop_s & ~head_s;
  assign data_data_ok = pop_s & head_s;
  assign inst_rdata   = mem_rdata;
  assign data_rdata   = mem_rdata;

  // Owner FIFO next state: push the winner on accept, pop the head on response
  always_comb begin
    owner_d  = owner_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (accept_s) begin
      owner_d[wr_ptr_q] = sel_data_s;
      wr_ptr_d          = ptr_inc(wr_ptr_q);
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (pop_s) begin
      rd_ptr_d = ptr_inc(rd_ptr_q);
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    case ({accept_s, pop_s})
      2'b10:   cnt_d = cnt_q + CNT_W'(1);
      2'b01:   cnt_d = cnt_q - CNT_W'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  // State and FIFO registers
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      owner_q  <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      owner_q  <= owner_d;
    end
  end

endmodule

// File: tb/tb_sram_bus_arbiter.sv
// Directed table-driven bench for sram_bus_arbiter: per-cycle vectors with hand-computed
// grants and response routing, plus hand-written reset-abort sequence.
module tb_sram_bus_arbiter;

  logic        clk;
  logic        resetn;
  logic        inst_req, inst_wr;
  logic [1:0]  inst_size;
  logic [3:0]  inst_wstrb;
  logic [31:0] inst_addr, inst_wdata;
  logic        inst_addr_ok, inst_data_ok;
  logic [31:0] inst_rdata;
  logic        data_req, data_wr;
  logic [1:0]  data_size;
  logic [3:0]  data_wstrb;
  logic [31:0] data_addr, data_wdata;
  logic        data_addr_ok, data_data_ok;
  logic [31:0] data_rdata;
  logic        mem_req, mem_wr;
  logic [1:0]  mem_size;
  logic [3:0]  mem_wstrb;
  logic [31:0] mem_addr, mem_wdata;
  logic        mem_addr_ok, mem_data_ok;
  logic [31:0] mem_rdata;

  int n_chk;
  int n_fail;

  sram_bus_arbiter #(.MAX_OUTST(4)) dut (
    .clk(clk), .resetn(resetn),
    .inst_req(inst_req), .inst_wr(inst_wr), .inst_size(inst_size), .inst_wstrb(inst_wstrb),
    .inst_addr(inst_addr), .inst_wdata(inst_wdata),
    .inst_addr_ok(inst_addr_ok), .inst_data_ok(inst_data_ok), .inst_rdata(inst_rdata),
    .data_req(data_req), .data_wr(data_wr), .data_size(data_size), .data_wstrb(data_wstrb),
    .data_addr(data_addr), .data_wdata(data_wdata),
    .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok), .data_rdata(data_rdata),
    .mem_req(mem_req), .mem_wr(mem_wr), .mem_size(mem_size), .mem_wstrb(mem_wstrb),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_addr_ok(mem_addr_ok), .mem_data_ok(mem_data_ok), .mem_rdata(mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        ireq;
    logic        dreq;
    logic        aok;
    logic        dok;
    logic [31:0] rdata;
    logic        e_mreq;
    logic        e_sel;   // 0 = inst fields on mem_*, 1 = data fields
    logic        e_iaok;
    logic        e_daok;
    logic        e_idok;
    logic        e_ddok;
  } vec_t;

  vec_t vecs[$];

  localparam logic [31:0] I_ADDR  = 32'h1000_0040;
  localparam logic [31:0] I_WDATA = 32'hAAAA_0001;
  localparam logic [31:0] D_ADDR  = 32'h2000_0080;
  localparam logic [31:0] D_WDATA = 32'hBBBB_0002;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic add(input logic ireq, input logic dreq, input logic aok, input logic dok,
                     input logic [31:0] rdata, input logic e_mreq, input logic e_sel,
                     input logic e_iaok, input logic e_daok, input logic e_idok, input logic e_ddok);
    vec_t v;
    v.ireq = ireq; v.dreq = dreq; v.aok = aok; v.dok = dok; v.rdata = rdata;
    v.e_mreq = e_mreq; v.e_sel = e_sel; v.e_iaok = e_iaok; v.e_daok = e_daok;
    v.e_idok = e_idok; v.e_ddok = e_ddok;
    vecs.push_back(v);
  endtask

  task automatic drive(input logic ireq, input logic dreq, input logic aok, input logic dok,
                       input logic [31:0] rdata);
    inst_req = ireq; data_req = dreq; mem_addr_ok = aok; mem_data_ok = dok; mem_rdata = rdata;
  endtask

  task automatic chk_outs(input string tag, input logic e_mreq, input logic e_sel,
                          input logic e_iaok, input logic e_daok,
                          input logic e_idok, input logic e_ddok);
    chk({tag, ".mem_req"}, {31'd0, mem_req}, {31'd0, e_mreq});
    if (e_mreq) begin
      chk({tag, ".mem_addr"}, mem_addr, e_sel ? D_ADDR : I_ADDR);
      chk({tag, ".mem_wdata"}, mem_wdata, e_sel ? D_WDATA : I_WDATA);
      chk({tag, ".mem_ctl"}, {25'd0, mem_wr, mem_size, mem_wstrb},
          e_sel ? {25'd0, 1'b1, 2'd1, 4'h3} : {25'd0, 1'b0, 2'd2, 4'hf});
    end
    chk({tag, ".addr_ok"}, {30'd0, inst_addr_ok, data_addr_ok}, {30'd0, e_iaok, e_daok});
    chk({tag, ".data_ok"}, {30'd0, inst_data_ok, data_data_ok}, {30'd0, e_idok, e_ddok});
  endtask

  initial begin
    n_chk = 0; n_fail = 0;
    inst_wr = 1'b0; inst_size = 2'd2; inst_wstrb = 4'hf; inst_addr = I_ADDR; inst_wdata = I_WDATA;
    data_wr = 1'b1; data_size = 2'd1; data_wstrb = 4'h3; data_addr = D_ADDR; data_wdata = D_WDATA;

    // Test 1: simultaneous requests, data first then inst
    add(1'b1, 1'b1, 1'b1, 1'b0, 32'h0,  1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    add(1'b1, 1'b0, 1'b1, 1'b0, 32'h0,  1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    add(1'b0, 1'b0, 1'b0, 1'b1, 32'h22, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    add(1'b0, 1'b0, 1'b0, 1'b1, 32'h11, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    // Test 5: response with empty FIFO is dropped
    add(1'b0, 1'b0, 1'b0, 1'b1, 32'h55, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    // Test 2: inst held 3 cycles, data ignored while locked
    add(1'b1, 1'b0, 1'b0, 1'b0, 32'h0,  1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    add(1'b1, 1'b1, 1'b0, 1'b0, 32'h0,  1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    add(1'b1, 1'b1, 1'b0, 1'b0, 32'h0,  1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    add(1'b1, 1'b1, 1'b1, 1'b0, 32'h0,  1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    add(1'b0, 1'b1, 1'b1, 1'b0, 32'h0,  1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    // data held one cycle, then inst fills the FIFO (I,D,D,I)
    add(1'b1, 1'b1, 1'b0, 1'b0, 32'h0,  1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    add(1'b1, 1'b1, 1'b1, 1'b0, 32'h0,  1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    add(1'b1, 1'b0, 1'b1, 1'b0, 32'h0,  1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    // Test 3: full blocks grants, even in the cycle a slot frees
    add(1'b1, 1'b1, 1'b1, 1'b0, 32'h0,  1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    add(1'b1, 1'b1, 1'b1, 1'b1, 32'h33, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    add(1'b1, 1'b1, 1'b1, 1'b0, 32'h0,  1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    add(1'b1, 1'b0, 1'b1, 1'b1, 32'h44, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    // simultaneous push and pop with pointer wrap; leaves I,D,I outstanding
    add(1'b1, 1'b0, 1'b1, 1'b1, 32'h66, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
    // Test 4: in-order routing I,D,I
    add(1'b0, 1'b0, 1'b0, 1'b1, 32'h11, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    add(1'b0, 1'b0, 1'b0, 1'b1, 32'h22, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    add(1'b0, 1'b0, 1'b0, 1'b1, 32'h33, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    add(1'b0, 1'b0, 1'b0, 1'b1, 32'h77, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

    // Reset state: outputs idle while resetn is low even with active inputs
    resetn = 1'b0;
    drive(1'b1, 1'b1, 1'b1, 1'b1, 32'hDEAD_BEEF);
    #2;
    chk_outs("reset", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    @(posedge clk); #1;
    resetn = 1'b1;
    drive(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    @(posedge clk); #1;

    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i].ireq, vecs[i].dreq, vecs[i].aok, vecs[i].dok, vecs[i].rdata);
      #2;
      chk_outs($sformatf("vec%0d", i), vecs[i].e_mreq, vecs[i].e_sel, vecs[i].e_iaok,
               vecs[i].e_daok, vecs[i].e_idok, vecs[i].e_ddok);
      if (vecs[i].e_idok) chk($sformatf("vec%0d.inst_rdata", i), inst_rdata, vecs[i].rdata);
      if (vecs[i].e_ddok) chk($sformatf("vec%0d.data_rdata", i), data_rdata, vecs[i].rdata);
      @(posedge clk); #1;
    end

    // Test 6: two outstanding plus a stalled data request, then reset
    drive(1'b1, 1'b0, 1'b1, 1'b0, 32'h0);
    @(posedge clk); #1;
    drive(1'b0, 1'b1, 1'b1, 1'b0, 32'h0);
    @(posedge clk); #1;
    drive(1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
    #2;
    chk_outs("r6.holdd", 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    @(posedge clk); #3;
    resetn = 1'b0;
    drive(1'b1, 1'b1, 1'b1, 1'b1, 32'h99);
    #1;
    chk_outs("r6.inrst", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    @(posedge clk); #1;
    resetn = 1'b1;
    drive(1'b0, 1'b0, 1'b0, 1'b1, 32'h88);
    #2;
    chk_outs("r6.empty", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    @(posedge clk); #1;
    drive(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
    #2;
    chk_outs("r6.idle", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    @(posedge clk); #1;
    drive(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
